// File: rtl/keypad_pkg.sv
// ============================================================================
// Module : keypad_pkg
// Shared types and helpers for the keypad event encoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package keypad_pkg;

    // Helpers operate on a fixed-width vector; callers zero-extend into it.
    localparam int MAX_KEYS   = 64;
    localparam int MAX_CODE_W = 6;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HELD = 1'b1
    } state_t;

    // Highest set index wins; an all-zero vector yields 0.
    function automatic logic [MAX_CODE_W-1:0] prio_encode(input logic [MAX_KEYS-1:0] vec);
        logic [MAX_CODE_W-1:0] result;
        result = '0;
        for (int i = 0; i < MAX_KEYS; i++) begin
            if (vec[i]) begin
                result = MAX_CODE_W'(i);
            end
        end
        return result;
    endfunction

    function automatic logic popcount_gt1(input logic [MAX_KEYS-1:0] vec);
        return |(vec & (vec - MAX_KEYS'(1)));
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_debounce.sv
// ============================================================================
// Module : keypad_debounce
// Two-flop synchroniser plus vector-wide debounce of the raw key lines.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int N_KEYS          = 10,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] keypad,
    output logic [N_KEYS-1:0] deb
);

    localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_KEYS-1:0] s1;
    logic [N_KEYS-1:0] s2;
    logic [N_KEYS-1:0] cand;
    logic [CNT_W-1:0]  cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= keypad;
            s2 <= s1;
        end
    end

    // Any change of the synchronised vector restarts the stability window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand <= '0;
            cnt  <= '0;
            deb  <= '0;
        end else if (s2 != cand) begin
            cand <= s2;
            cnt  <= '0;
        end else if (cnt == CNT_LAST) begin
            deb  <= cand;
        end else begin
            cnt  <= cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/keypad_event_encoder.sv
// ============================================================================
// Module : keypad_event_encoder
// Debounced, priority-encoded keypad with one strobe per fresh press.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module keypad_event_encoder
    import keypad_pkg::*;
#(
    parameter int N_KEYS          = 10,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CODE_W          = $clog2(N_KEYS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enablen,
    input  logic [N_KEYS-1:0] keypad,
    output logic [CODE_W-1:0] code,
    output logic              key_valid,
    output logic              all_off,
    output logic              multi
);

    logic [N_KEYS-1:0]   deb;
    logic [MAX_KEYS-1:0] deb_ext;
    state_t              state;
    state_t              state_next;
    logic                key_valid_next;
    logic [CODE_W-1:0]   code_next;

    keypad_debounce #(
        .N_KEYS          (N_KEYS),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .keypad (keypad),
        .deb    (deb)
    );

    always_comb begin
        deb_ext             = '0;
        deb_ext[N_KEYS-1:0] = deb;
    end

    // A press seen while disabled still moves to S_HELD, so it needs a release first.
    always_comb begin
        state_next     = state;
        key_valid_next = 1'b0;
        code_next      = code;
        case (state)
            S_IDLE: begin
                if (deb != '0) begin
                    state_next = S_HELD;
                    if (!enablen) begin
                        key_valid_next = 1'b1;
                        code_next      = CODE_W'(prio_encode(deb_ext));
                    end
                end
            end
            S_HELD: begin
                if (deb == '0) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            key_valid <= 1'b0;
            code      <= '0;
            all_off   <= 1'b1;
            multi     <= 1'b0;
        end else begin
            state     <= state_next;
            key_valid <= key_valid_next;
            code      <= code_next;
            all_off   <= (deb == '0);
            multi     <= popcount_gt1(deb_ext);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_keypad_event_encoder.sv
// ============================================================================
// Module : tb_keypad_event_encoder
// Directed self-checking bench for keypad_event_encoder (default parameters).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_keypad_event_encoder;

    logic       clk;
    logic       rst;
    logic       enablen;
    logic [9:0] keypad;
    logic [3:0] code;
    logic       key_valid;
    logic       all_off;
    logic       multi;

    int checks;
    int errors;

    keypad_event_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .enablen   (enablen),
        .keypad    (keypad),
        .code      (code),
        .key_valid (key_valid),
        .all_off   (all_off),
        .multi     (multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        enablen = 1'b0;
        keypad  = '0;
        repeat (3) tick();
        checks++;
        if (all_off !== 1'b1 || code !== 4'd0 || key_valid !== 1'b0 || multi !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: all_off=%b code=%0d key_valid=%b multi=%b, need 1 0 0 0",
                     all_off, code, key_valid, multi);
        end
        rst = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_clean_press();
        keypad = 10'b1 << 7;
        for (int e = 1; e <= 7; e++) begin
            tick();
            checks++;
            if (key_valid !== 1'b0) begin
                errors++;
                $display("FAIL press7_early_strobe: key_valid=%b at edge %0d, need 0", key_valid, e);
            end
        end
        tick();
        checks++;
        if (key_valid !== 1'b1 || code !== 4'd7 || all_off !== 1'b0 || multi !== 1'b0) begin
            errors++;
            $display("FAIL press7_edge8: key_valid=%b code=%0d all_off=%b multi=%b, need 1 7 0 0",
                     key_valid, code, all_off, multi);
        end
        tick();
        checks++;
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL press7_single_cycle: key_valid=%b at edge 9, need 0", key_valid);
        end
        keypad = '0;
        repeat (7) tick();
        checks++;
        if (all_off !== 1'b0) begin
            errors++;
            $display("FAIL release7_early: all_off=%b at edge 7, need 0", all_off);
        end
        tick();
        checks++;
        if (all_off !== 1'b1 || code !== 4'd7) begin
            errors++;
            $display("FAIL release7_edge8: all_off=%b code=%0d, need 1 7", all_off, code);
        end
        repeat (2) tick();
    endtask

    task automatic test_bounce();
        for (int c = 0; c < 20; c++) begin
            keypad = (((c / 2) % 2) == 0) ? (10'b1 << 3) : 10'b0;
            tick();
            checks++;
            if (key_valid !== 1'b0 || all_off !== 1'b1) begin
                errors++;
                $display("FAIL bounce_leak: key_valid=%b all_off=%b in cycle %0d, need 0 1",
                         key_valid, all_off, c);
            end
        end
        keypad = 10'b1 << 3;
        for (int e = 1; e <= 7; e++) begin
            tick();
            checks++;
            if (key_valid !== 1'b0) begin
                errors++;
                $display("FAIL bounce_early_strobe: key_valid=%b at edge %0d, need 0", key_valid, e);
            end
        end
        tick();
        checks++;
        if (key_valid !== 1'b1 || code !== 4'd3) begin
            errors++;
            $display("FAIL bounce_strobe: key_valid=%b code=%0d, need 1 3", key_valid, code);
        end
        keypad = '0;
        repeat (10) tick();
    endtask

    task automatic test_multi_hold();
        keypad = 10'b1 << 2;
        repeat (8) tick();
        checks++;
        if (key_valid !== 1'b1 || code !== 4'd2) begin
            errors++;
            $display("FAIL hold2_strobe: key_valid=%b code=%0d, need 1 2", key_valid, code);
        end
        repeat (3) tick();
        keypad = (10'b1 << 2) | (10'b1 << 9);
        for (int e = 1; e <= 10; e++) begin
            tick();
            checks++;
            if (key_valid !== 1'b0) begin
                errors++;
                $display("FAIL add9_second_strobe: key_valid=%b at edge %0d, need 0", key_valid, e);
            end
        end
        checks++;
        if (multi !== 1'b1 || code !== 4'd2 || all_off !== 1'b0) begin
            errors++;
            $display("FAIL add9_state: multi=%b code=%0d all_off=%b, need 1 2 0", multi, code, all_off);
        end
        keypad = '0;
        repeat (8) tick();
        checks++;
        if (all_off !== 1'b1 || multi !== 1'b0) begin
            errors++;
            $display("FAIL release_both: all_off=%b multi=%b, need 1 0", all_off, multi);
        end
        repeat (2) tick();
        keypad = 10'b1 << 9;
        repeat (8) tick();
        checks++;
        if (key_valid !== 1'b1 || code !== 4'd9 || multi !== 1'b0) begin
            errors++;
            $display("FAIL press9_strobe: key_valid=%b code=%0d multi=%b, need 1 9 0", key_valid, code, multi);
        end
        keypad = '0;
        repeat (10) tick();
    endtask

    task automatic test_enable();
        enablen = 1'b1;
        keypad  = 10'b1 << 5;
        for (int e = 1; e <= 12; e++) begin
            tick();
            checks++;
            if (key_valid !== 1'b0) begin
                errors++;
                $display("FAIL disabled_strobe: key_valid=%b at edge %0d, need 0", key_valid, e);
            end
        end
        checks++;
        if (all_off !== 1'b0 || code !== 4'd9) begin
            errors++;
            $display("FAIL disabled_state: all_off=%b code=%0d, need 0 9", all_off, code);
        end
        enablen = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            checks++;
            if (key_valid !== 1'b0) begin
                errors++;
                $display("FAIL enable_midhold_strobe: key_valid=%b at cycle %0d, need 0", key_valid, e);
            end
        end
        keypad = '0;
        repeat (10) tick();
        keypad = 10'b1 << 5;
        repeat (7) tick();
        checks++;
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL repress5_early: key_valid=%b at edge 7, need 0", key_valid);
        end
        tick();
        checks++;
        if (key_valid !== 1'b1 || code !== 4'd5) begin
            errors++;
            $display("FAIL repress5_strobe: key_valid=%b code=%0d, need 1 5", key_valid, code);
        end
        keypad = '0;
        repeat (10) tick();
    endtask

    task automatic test_simultaneous();
        int strobes;
        keypad = (10'b1 << 0) | (10'b1 << 4) | (10'b1 << 8);
        repeat (8) tick();
        checks++;
        if (key_valid !== 1'b1 || code !== 4'd8 || multi !== 1'b1) begin
            errors++;
            $display("FAIL simul_strobe: key_valid=%b code=%0d multi=%b, need 1 8 1", key_valid, code, multi);
        end
        strobes = 0;
        for (int e = 0; e < 12; e++) begin
            tick();
            if (key_valid === 1'b1) strobes++;
        end
        checks++;
        if (strobes !== 0) begin
            errors++;
            $display("FAIL simul_extra_strobes: got %0d extra strobes, need 0", strobes);
        end
        keypad = '0;
        repeat (10) tick();
    endtask

    task automatic test_reset_mid_press();
        keypad = 10'b1 << 6;
        repeat (7) tick();
        // deb now holds key 6; reset lands before the edge that would strobe
        rst = 1'b1;
        #1;
        checks++;
        if (all_off !== 1'b1 || code !== 4'd0 || key_valid !== 1'b0 || multi !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: all_off=%b code=%0d key_valid=%b multi=%b, need 1 0 0 0",
                     all_off, code, key_valid, multi);
        end
        repeat (3) tick();
        checks++;
        if (all_off !== 1'b1 || code !== 4'd0 || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_hold: all_off=%b code=%0d key_valid=%b, need 1 0 0",
                     all_off, code, key_valid);
        end
        rst = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            checks++;
            if (key_valid !== 1'b0) begin
                errors++;
                $display("FAIL postreset_early: key_valid=%b at edge %0d, need 0", key_valid, e);
            end
        end
        tick();
        checks++;
        if (key_valid !== 1'b1 || code !== 4'd6) begin
            errors++;
            $display("FAIL postreset_strobe: key_valid=%b code=%0d, need 1 6", key_valid, code);
        end
        keypad = '0;
        repeat (10) tick();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        enablen = 1'b0;
        keypad  = '0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_multi_hold();
        test_enable();
        test_simultaneous();
        test_reset_mid_press();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
